rr_sched: RTL and testbench

Parameterised round-robin scheduler that shares one resource between N requesters under the req/gnt protocol already used by the three-way arbiter: requests stay high until granted, and a granted requester keeps its request high for its whole tenure. It adds an optional turnaround gap between tenures and a tenure-overrun monitor. It sits between the masters and the shared resource and produces one-hot grants plus an encoded owner index for the resource-side mux.

---
 rtl/rr_sched_pkg.sv | 32 +++
 rtl/rr_pick.sv | 37 +++
 rtl/rr_sched.sv | 154 +++++++++++++++
 tb/tb_rr_sched.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin scheduler.
package rr_sched_pkg;

  // Scheduler phases: waiting, owner holds the resource, post-release gap.
  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StTurn
  } state_t;

  // Widest requester vector the helpers are sized for.
  localparam int unsigned MaxN    = 16;
  localparam int unsigned MaxIdxW = 4;

  // Index width for n requesters; never narrower than one bit.
  function automatic int unsigned rr_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Encode a one-hot vector; OR-reduction avoids a priority chain.
  function automatic logic [MaxIdxW-1:0] rr_onehot2idx(input logic [MaxN-1:0] onehot);
    logic [MaxIdxW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (onehot[i]) begin
        idx = idx | MaxIdxW'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: the first set request at or above ptr wins, wrapping to 0.
module rr_pick import rr_sched_pkg::*; #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = rr_idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    win,
  output logic            any
);

  logic            found;
  int unsigned     idx;
  logic [IdxW-1:0] sel;

  // Walk ptr, ptr+1, ..., N-1, 0, ... and keep only the first hit.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      sel = IdxW'(idx);
      if (!found && req[sel]) begin
        win[sel] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_sched.sv
// Round-robin scheduler for N req/gnt masters with optional turnaround gap and
// tenure-overrun monitor.
module rr_sched import rr_sched_pkg::*; #(
  parameter int unsigned N          = 3,
  parameter int unsigned TURNAROUND = 0,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned IdxW  = rr_idx_w(N);
  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned TurnW = 4;

  localparam logic [HoldW-1:0] HoldMax  = HoldW'(MAX_HOLD);
  localparam logic [TurnW-1:0] TurnLoad = (TURNAROUND > 0) ? TurnW'(TURNAROUND - 1) : '0;

  state_t           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IdxW-1:0]  id_q, id_d;
  logic [IdxW-1:0]  ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [TurnW-1:0] turn_q, turn_d;
  // Set once the overrun pulse has fired for the current tenure.
  logic             ovr_done_q, ovr_done_d;

  logic [N-1:0]    pick_req;
  logic [N-1:0]    pick_win;
  logic            pick_any;
  logic [IdxW-1:0] pick_ptr;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] next_ptr;
  logic            grant_new;

  // Pointer the owner's release will install; also used for the direct handoff.
  assign next_ptr = (id_q == IdxW'(N - 1)) ? '0 : id_q + IdxW'(1);

  // During a tenure the picker already searches from the post-release pointer.
  assign pick_ptr = (state_q == StGrant) ? next_ptr : ptr_q;
  assign pick_req = req & ~gnt_q;

  rr_pick #(
    .N    (N),
    .IdxW (IdxW)
  ) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .win (pick_win),
    .any (pick_any)
  );

  assign pick_idx = IdxW'(rr_onehot2idx(MaxN'(pick_win)));

  assign gnt     = gnt_q;
  assign gnt_id  = id_q;
  assign busy    = (state_q == StGrant);
  assign overrun = (state_q == StGrant) && (hold_q == HoldMax) && (|(req & ~gnt_q)) &&
                   !ovr_done_q;

  // Next-state: arbitration, release handling, tenure and turnaround counting.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    ovr_done_d = ovr_done_q;
    grant_new  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_new = 1'b1;
        end
      end
      StGrant: begin
        if (!req[id_q]) begin
          gnt_d = '0;
          id_d  = '0;
          ptr_d = next_ptr;
          if (TURNAROUND == 0) begin
            if (pick_any) begin
              grant_new = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end else begin
            state_d = StTurn;
            turn_d  = TurnLoad;
          end
        end else begin
          if (hold_q != HoldMax) begin
            hold_d = hold_q + HoldW'(1);
          end
          if (overrun) begin
            ovr_done_d = 1'b1;
          end
        end
      end
      StTurn: begin
        if (turn_q == '0) begin
          if (pick_any) begin
            grant_new = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end else begin
          turn_d = turn_q - TurnW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A new tenure counts its first grant cycle as 1.
    if (grant_new) begin
      state_d    = StGrant;
      gnt_d      = pick_win;
      id_d       = pick_idx;
      hold_d     = HoldW'(1);
      ovr_done_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset drops any grant immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      id_q       <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      turn_q     <= '0;
      ovr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      turn_q     <= turn_d;
      ovr_done_q <= ovr_done_d;
    end
  end

endmodule

// File: tb/tb_rr_sched.sv
// Bench for rr_sched: three configurations against a tenure-level model plus
// hand-computed directed checks.
module tb_rr_sched;

  logic clk;
  logic rst;

  // a: N=3, no gap, MAX_HOLD=4; b: N=3, gap 2; c: N=5, no gap.
  logic [2:0] req_a, gnt_a, req_b, gnt_b;
  logic [4:0] req_c, gnt_c;
  logic [1:0] id_a, id_b;
  logic [2:0] id_c;
  logic busy_a, busy_b, busy_c, ovr_a, ovr_b, ovr_c;

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_en  = 1'b0;

  rr_sched #(.N(3), .TURNAROUND(0), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .gnt_id(id_a), .busy(busy_a),
    .overrun(ovr_a)
  );
  rr_sched #(.N(3), .TURNAROUND(2), .MAX_HOLD(16)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .gnt_id(id_b), .busy(busy_b),
    .overrun(ovr_b)
  );
  rr_sched #(.N(5), .TURNAROUND(0), .MAX_HOLD(16)) dut_c (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .gnt_id(id_c), .busy(busy_c),
    .overrun(ovr_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tenure-level view: who owns the resource, for how many cycles, how many idle
  // cycles remain before the next grant may be issued.
  typedef struct packed {
    int owner;
    int ptr;
    int gap;
    int tenure;
    bit flagged;
  } mstate_t;

  function automatic mstate_t model_reset();
    mstate_t o;
    o.owner = -1; o.ptr = 0; o.gap = 0; o.tenure = 0; o.flagged = 1'b0;
    return o;
  endfunction

  function automatic bit model_ovr(mstate_t s, logic [15:0] r, int n, int mh);
    bit pend;
    pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (r[4'(i)] && i != s.owner) pend = 1'b1;
    end
    return (s.owner >= 0) && (s.tenure >= mh) && pend && !s.flagged;
  endfunction

  function automatic mstate_t model_step(mstate_t s, logic [15:0] r, logic rs, int n, int ta,
                                         int mh);
    mstate_t o;
    bit      can_pick;
    int      c;
    o = s;
    can_pick = 1'b0;
    if (rs) return model_reset();
    if (s.owner >= 0) begin
      if (model_ovr(s, r, n, mh)) o.flagged = 1'b1;
      if (r[4'(s.owner)]) begin
        o.tenure = s.tenure + 1;
      end else begin
        o.owner = -1;
        o.ptr   = (s.owner + 1) % n;
        if (ta == 0) can_pick = 1'b1;
        else o.gap = ta;
      end
    end else if (s.gap > 1) begin
      o.gap = s.gap - 1;
    end else begin
      o.gap = 0;
      can_pick = 1'b1;
    end
    if (can_pick) begin
      for (int k = 0; k < n; k++) begin
        c = (o.ptr + k) % n;
        if (o.owner < 0 && r[4'(c)] && c != s.owner) begin
          o.owner   = c;
          o.tenure  = 1;
          o.flagged = 1'b0;
        end
      end
    end
    return o;
  endfunction

  mstate_t m_a = model_reset();
  mstate_t m_b = model_reset();
  mstate_t m_c = model_reset();

  always @(posedge clk) begin
    m_a <= model_step(m_a, 16'(req_a), rst, 3, 0, 4);
    m_b <= model_step(m_b, 16'(req_b), rst, 3, 2, 16);
    m_c <= model_step(m_c, 16'(req_c), rst, 5, 0, 16);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mstate_t m, input logic [15:0] r, input int n,
                     input int mh, input logic [15:0] g, input logic [3:0] id, input logic b,
                     input logic ov);
    logic [15:0] eg;
    eg = (m.owner >= 0) ? (16'd1 << m.owner) : 16'd0;
    check({tag, ".gnt"}, 32'(g), 32'(eg));
    check({tag, ".busy"}, 32'(b), 32'(m.owner >= 0));
    if (m.owner >= 0) check({tag, ".gnt_id"}, 32'(id), 32'(m.owner));
    check({tag, ".overrun"}, 32'(ov), 32'(model_ovr(m, r, n, mh)));
  endtask

  // Every cycle, mid-period: DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a", m_a, 16'(req_a), 3, 4, 16'(gnt_a), 4'(id_a), busy_a, ovr_a);
      cmp("b", m_b, 16'(req_b), 3, 16, 16'(gnt_b), 4'(id_b), busy_b, ovr_b);
      cmp("c", m_c, 16'(req_c), 5, 16, 16'(gnt_c), 4'(id_c), busy_c, ovr_c);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int own;

  initial begin
    rst = 1'b1; req_a = '0; req_b = '0; req_c = '0;
    tick();
    chk_en = 1'b1;
    check("rst.gnt_a", 32'(gnt_a), 0);
    check("rst.busy_a", 32'(busy_a), 0);
    tick();
    rst = 1'b0;
    tick();

    // Round-robin: all three request; each owner keeps 2 cycles then re-requests.
    req_a = 3'b111;
    tick();
    for (int i = 0; i < 6; i++) begin
      own = i % 3;
      check("rr.gnt_c1", 32'(gnt_a), 32'(3'b001 << own));
      check("rr.id", 32'(id_a), 32'(own));
      tick();
      check("rr.gnt_c2", 32'(gnt_a), 32'(3'b001 << own));
      req_a[own] = 1'b0;
      tick();
      check("rr.handoff_busy", 32'(busy_a), 1);
      req_a[own] = 1'b1;
    end
    req_a = '0;
    tick();
    check("rr.end_gnt", 32'(gnt_a), 0);

    // Single request: one-cycle grant and release latency.
    req_a = 3'b001;
    tick();
    check("single.gnt", 32'(gnt_a), 32'(3'b001));
    req_a = '0;
    tick();
    check("single.rel_gnt", 32'(gnt_a), 0);
    check("single.rel_busy", 32'(busy_a), 0);

    // Overrun: owner 1 holds 10 cycles with req2 pending; pulse only in cycle 4.
    req_a = 3'b110;
    tick();
    check("ovr.gnt", 32'(gnt_a), 32'(3'b010));
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("ovr.c%0d", k), 32'(ovr_a), 32'(k == 4));
      if (k == 10) req_a[1] = 1'b0;
      tick();
    end
    check("ovr.next_owner", 32'(gnt_a), 32'(3'b100));
    req_a = '0;
    tick();

    // No pending request: no pulse; a request arriving late pulses at once.
    req_a = 3'b010;
    tick();
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("late.c%0d", k), 32'(ovr_a), 0);
      if (k == 6) begin
        req_a[0] = 1'b1;
        #1;
        check("late.pulse", 32'(ovr_a), 1);
      end
      if (k == 8) req_a[1] = 1'b0;
      tick();
    end
    check("late.handoff", 32'(gnt_a), 32'(3'b001));
    req_a = '0;
    tick();

    // Turnaround of 2 on dut_b.
    req_b = 3'b001;
    tick();
    check("turn.gnt0", 32'(gnt_b), 32'(3'b001));
    req_b = 3'b011;
    tick();
    req_b = 3'b010;
    tick();
    check("turn.gap1", 32'(busy_b), 0);
    tick();
    check("turn.gap2", 32'(busy_b), 0);
    tick();
    check("turn.gnt1", 32'(gnt_b), 32'(3'b010));
    req_b = '0;
    tick();
    tick();
    tick();

    // Wrap on dut_c: pointer parked at 4, then 0 wins before 1.
    req_c = 5'b01000;
    tick();
    check("wrap.gnt3", 32'(gnt_c), 32'(5'b01000));
    req_c = '0;
    tick();
    req_c = 5'b00011;
    tick();
    check("wrap.gnt0", 32'(gnt_c), 32'(5'b00001));
    req_c = 5'b00010;
    tick();
    check("wrap.gnt1", 32'(gnt_c), 32'(5'b00010));
    check("wrap.id1", 32'(id_c), 1);
    req_c = '0;
    tick();

    // Reset mid-tenure on dut_a.
    req_a = 3'b010;
    tick();
    check("mid.gnt1", 32'(gnt_a), 32'(3'b010));
    rst = 1'b1;
    tick();
    check("mid.gnt", 32'(gnt_a), 0);
    check("mid.id", 32'(id_a), 0);
    check("mid.busy", 32'(busy_a), 0);
    check("mid.ovr", 32'(ovr_a), 0);
    rst = 1'b0;
    req_a = 3'b001;
    tick();
    check("mid.regrant", 32'(gnt_a), 32'(3'b001));
    req_a = '0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
